period_meter: RTL and testbench

- Measures the period and high time of a slow, clock-like input signal, counted in cycles of the system clock.
- Acts as the receive-side counterpart of the team's programmable frequency divider. Given a divided clock, it recovers the divide value T and the duty split, and reports them to the register/control logic.
- Also used in loopback checks of divider configuration.

---
 rtl/freq_pkg.sv | 12 +
 rtl/sync_edge_detect.sv | 31 +++
 rtl/period_meter.sv | 114 +++++++++++
 tb/tb_period_meter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared constants and state encoding for the divider/meter family
package freq_pkg;

  localparam int DEFAULT_CW = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer with rise/fall detection
// Rise and fall share the same pipeline depth so measured widths carry no bias.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync    <= '0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_level_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_level_d;
  assign o_fall  = ~o_level & r_level_d;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures period and high time of a slow input in clock cycles
// Continuous rise-to-rise measurement with a sticky timeout when edges stop.
module period_meter
  import freq_pkg::*;
#(
  parameter int            CW          = DEFAULT_CW,
  parameter logic [CW-1:0] TIMEOUT     = {CW{1'b1}},
  parameter int            SYNC_STAGES = 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_enable,
  input  logic          i_sig_in,
  output logic [CW-1:0] o_period,
  output logic [CW-1:0] o_high_time,
  output logic          o_valid,
  output logic          o_timeout,
  output logic          o_busy
);

  localparam logic [CW-1:0] ONE = CW'(1);

  meter_state_t  r_state;
  meter_state_t  w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_hcnt;
  logic [CW-1:0] r_period;
  logic [CW-1:0] r_high_time;
  logic          r_high_phase;
  logic          r_valid;
  logic          r_timeout;
  logic          w_level;
  logic          w_rise;
  logic          w_fall;
  logic          w_cnt_at_limit;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_sig_in),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_cnt_at_limit = (r_cnt == TIMEOUT);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_enable) w_state_nxt = ARM;
      ARM:     if (w_rise) w_state_nxt = MEASURE;
      MEASURE: if (!w_rise && w_cnt_at_limit) w_state_nxt = ARM;
      default: w_state_nxt = IDLE;
    endcase
    if (!i_enable) w_state_nxt = IDLE;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_hcnt       <= '0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_high_phase <= 1'b0;
      r_valid      <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!i_enable || r_state == IDLE) begin
        r_cnt        <= '0;
        r_hcnt       <= '0;
        r_high_phase <= 1'b0;
        if (i_enable) r_timeout <= 1'b0;
      end else if (w_rise) begin
        // The arming rise only opens the window; later rises close one and open the next.
        if (r_state == MEASURE) begin
          r_period    <= r_cnt;
          r_high_time <= r_hcnt;
          r_valid     <= 1'b1;
        end
        r_cnt        <= ONE;
        r_hcnt       <= ONE;
        r_high_phase <= 1'b1;
      end else if (w_cnt_at_limit) begin
        r_timeout <= 1'b1;
        if (r_state == MEASURE) begin
          r_cnt        <= '0;
          r_hcnt       <= '0;
          r_high_phase <= 1'b0;
        end
      end else begin
        r_cnt <= r_cnt + ONE;
        // Level is low exactly on the fall cycle, so the high count stops at H.
        if (r_high_phase && w_level) r_hcnt <= r_hcnt + ONE;
        if (w_fall) r_high_phase <= 1'b0;
      end
    end
  end

  assign o_period    = r_period;
  assign o_high_time = r_high_time;
  assign o_valid     = r_valid & i_enable;
  assign o_timeout   = r_timeout;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - self-checking bench for period_meter
`timescale 1ns/1ps
module tb_period_meter;

  localparam int CW = 32;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          sig = 1'b0;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          valid;
  logic          timeout;
  logic          busy;

  period_meter #(
    .CW          (CW),
    .TIMEOUT     (32'(TO)),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_enable    (en),
    .i_sig_in    (sig),
    .o_period    (period),
    .o_high_time (high_time),
    .o_valid     (valid),
    .o_timeout   (timeout),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input logic [31:0] act, input int lo, input int hi);
    n_tests++;
    if (int'(act) < lo || int'(act) > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Reference model: works on the edge index at which each input sample was taken.
  // A sample taken at edge n is acted on two edges later; widths are differences of edge indices.
  typedef enum {M_IDLE, M_ARM, M_RUN} mmode_t;
  mmode_t mode = M_IDLE;
  int     k = 0;
  int     k_rst = 0;
  bit     samp [0:63];
  int     arm_start = 0;
  int     last_rise = 0;
  int     fall_at = -1;
  bit     m_valid = 1'b0;
  bit     m_to = 1'b0;
  int     m_per = 0;
  int     m_hi = 0;

  function automatic bit smp(input int i);
    if (i < k_rst) return 1'b0;
    return samp[i % 64];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mode    = M_IDLE;
      m_valid = 1'b0;
      m_to    = 1'b0;
      m_per   = 0;
      m_hi    = 0;
      k_rst   = k;
    end else begin
      bit r, f;
      samp[k % 64] = sig;
      r = smp(k - 2) && !smp(k - 3);
      f = !smp(k - 2) && smp(k - 3);
      m_valid = 1'b0;
      if (!en) begin
        mode = M_IDLE;
      end else begin
        case (mode)
          M_IDLE: begin
            mode = M_ARM;
            arm_start = k;
            m_to = 1'b0;
          end
          M_ARM: begin
            if (r) begin
              mode = M_RUN;
              last_rise = k;
              fall_at = -1;
            end else if (k - arm_start > TO) begin
              m_to = 1'b1;
            end
          end
          default: begin
            if (r) begin
              m_valid = 1'b1;
              m_per = k - last_rise;
              m_hi = (fall_at < 0) ? (k - last_rise) : (fall_at - last_rise);
              last_rise = k;
              fall_at = -1;
            end else if (k - last_rise >= TO) begin
              m_to = 1'b1;
              mode = M_ARM;
              arm_start = k;
            end else if (f && fall_at < 0) begin
              fall_at = k;
            end
          end
        endcase
      end
      k++;
    end
  end

  int cyc = 0;
  int n_valid = 0;
  int last_valid_cyc = -1;
  int prev_valid_cyc = -1;
  int to_rise_cyc = -1;
  bit to_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    chk("cyc_valid", 32'(valid), 32'(m_valid & en));
    chk("cyc_period", period, 32'(m_per));
    chk("cyc_high_time", high_time, 32'(m_hi));
    chk("cyc_timeout", 32'(timeout), 32'(m_to));
    chk("cyc_busy", 32'(busy), 32'(mode != M_IDLE));
    if (valid) begin
      n_valid++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
    end
    if (timeout && !to_prev) to_rise_cyc = cyc;
    to_prev = timeout;
  end

  // Caller is at posedge+2; drives n periods of t cycles with h cycles high.
  task automatic drive_div(input int t, input int h, input int n);
    for (int p = 0; p < n; p++) begin
      sig = 1'b1;
      repeat (h) @(posedge clk);
      #2;
      sig = 1'b0;
      repeat (t - h) @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int     nv;
    int     nv0;
    int     reen_valid;
    realtime off;

    #1;
    chk("rst_period", period, 0);
    chk("rst_high_time", high_time, 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #2 en = 1'b1;

    drive_div(4, 2, 8);
    chk("t4_period", period, 4);
    chk("t4_high", high_time, 2);
    chk("t4_spacing", 32'(last_valid_cyc - prev_valid_cyc), 4);
    drive_div(5, 2, 8);
    chk("t5_period", period, 5);
    chk("t5_high", high_time, 2);
    chk("t5_spacing", 32'(last_valid_cyc - prev_valid_cyc), 5);

    nv = n_valid;
    @(posedge clk);
    off = $urandom_range(100, 900) / 100.0;
    #(off);
    for (int p = 0; p < 5; p++) begin
      sig = 1'b1;
      #100;
      sig = 1'b0;
      #300;
    end
    @(posedge clk);
    #2;
    chk_range("async_period", period, 39, 41);
    chk_range("async_high", high_time, 9, 11);
    chk("async_valid_count", 32'(n_valid - nv), 5);

    drive_div(4, 2, 4);
    repeat (150) @(posedge clk);
    #2;
    chk("to_latency", 32'(to_rise_cyc - last_valid_cyc), 32'(TO));
    chk("to_period_kept", period, 4);
    chk("to_flag", 32'(timeout), 1);
    nv = n_valid;
    drive_div(5, 2, 4);
    chk("to_resume_valids", 32'(n_valid - nv), 3);
    chk("to_resume_period", period, 5);
    chk("to_still_set", 32'(timeout), 1);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("to_set_in_idle", 32'(timeout), 1);
    en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("to_cleared", 32'(timeout), 0);
    chk("reen_busy", 32'(busy), 1);

    drive_div(20, 10, 3);
    chk("p20_period", period, 20);
    chk("p20_high", high_time, 10);
    nv = n_valid;
    fork
      drive_div(20, 10, 3);
      begin
        repeat (9) @(posedge clk);
        #2 en = 1'b0;
        @(posedge clk);
        #1;
        chk("dis_busy", 32'(busy), 0);
        chk("dis_valid", 32'(valid), 0);
        chk("dis_period_kept", period, 20);
        nv0 = n_valid;
        repeat (14) @(posedge clk);
        chk("dis_no_valid", 32'(n_valid - nv0), 0);
        #2 en = 1'b1;
      end
    join
    chk("dis_fork_valids", 32'(n_valid - nv), 1);
    reen_valid = n_valid;
    drive_div(20, 10, 2);
    chk("reen_valids", 32'(n_valid - reen_valid), 2);
    chk("reen_period", period, 20);
    chk("reen_high", high_time, 10);

    fork
      drive_div(4, 2, 6);
      begin
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_period", period, 0);
        chk("arst_high_time", high_time, 0);
        chk("arst_valid", 32'(valid), 0);
        chk("arst_timeout", 32'(timeout), 0);
        chk("arst_busy", 32'(busy), 0);
        @(posedge clk);
        #2 rst = 1'b0;
      end
    join
    drive_div(4, 2, 4);
    chk("post_rst_period", period, 4);
    chk("post_rst_high", high_time, 2);

    drive_div(2, 1, 8);
    chk("min_period", period, 2);
    chk("min_high", high_time, 1);
    chk("min_spacing", 32'(last_valid_cyc - prev_valid_cyc), 2);

    en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
